// File: rtl/coin_credit_encoder.sv
// Vending machine front end: accumulates coin credit in nickels, presents it as
// a 4-bit display code, handles vend/cancel and pays change one nickel per cycle.
module coin_credit_encoder #(
    parameter int MAX_UNITS   = 12,
    parameter int PRICE_UNITS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       vend_req,
    input  logic       cancel,
    output logic       a3,
    output logic       a2,
    output logic       a1,
    output logic       a0,
    output logic       coin_reject,
    output logic       vend_ok,
    output logic       vend_deny,
    output logic       nickel_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_CREDIT   = 2'b01,
        ST_DISPENSE = 2'b10,
        ST_RETURN   = 2'b11
    } state_t;

    localparam logic [4:0] MAX_C   = 5'(MAX_UNITS);
    localparam logic [3:0] PRICE_C = 4'(PRICE_UNITS);

    // Slugs carry no value; they are rejected separately by coin_is_legal.
    function automatic logic [4:0] coin_value(input logic [1:0] t);
        logic [4:0] v;
        case (t)
            2'b00:   v = 5'd1;
            2'b01:   v = 5'd2;
            2'b10:   v = 5'd5;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    function automatic logic coin_is_legal(input logic [1:0] t);
        return (t != 2'b11);
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] credit_r;
    logic [3:0] credit_next_s;
    logic [4:0] sum_s;
    logic       reject_r;
    logic       reject_next_s;
    logic       ok_r;
    logic       ok_next_s;
    logic       deny_r;
    logic       deny_next_s;
    logic       nickel_r;
    logic       nickel_next_s;
    logic       busy_r;
    logic       busy_next_s;

    // Next-state, next-credit and next-pulse computation.
    always_comb begin
        state_next_s  = state_r;
        credit_next_s = credit_r;
        reject_next_s = 1'b0;
        ok_next_s     = 1'b0;
        deny_next_s   = 1'b0;
        nickel_next_s = 1'b0;
        sum_s         = {1'b0, credit_r} + coin_value(coin_type);

        case (state_r)
            ST_IDLE, ST_CREDIT: begin
                if (cancel && (state_r == ST_CREDIT)) begin
                    // First nickel leaves in the same cycle RETURN is entered.
                    state_next_s  = ST_RETURN;
                    credit_next_s = credit_r - 4'd1;
                    nickel_next_s = 1'b1;
                    reject_next_s = coin_valid;
                end else if (vend_req) begin
                    if (credit_r >= PRICE_C) begin
                        state_next_s  = ST_DISPENSE;
                        credit_next_s = credit_r - PRICE_C;
                        ok_next_s     = 1'b1;
                    end else begin
                        deny_next_s = 1'b1;
                    end
                    reject_next_s = coin_valid;
                end else if (coin_valid) begin
                    if (coin_is_legal(coin_type) && (sum_s <= MAX_C)) begin
                        state_next_s  = ST_CREDIT;
                        credit_next_s = sum_s[3:0];
                    end else begin
                        reject_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DISPENSE, ST_RETURN: begin
                reject_next_s = coin_valid;
                if (credit_r != 4'd0) begin
                    state_next_s  = ST_RETURN;
                    credit_next_s = credit_r - 4'd1;
                    nickel_next_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s  = ST_IDLE;
                credit_next_s = 4'd0;
            end
        endcase

        busy_next_s = (state_next_s == ST_DISPENSE) || (state_next_s == ST_RETURN);
    end

    // State, credit and output pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            credit_r <= 4'd0;
            reject_r <= 1'b0;
            ok_r     <= 1'b0;
            deny_r   <= 1'b0;
            nickel_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            credit_r <= credit_next_s;
            reject_r <= reject_next_s;
            ok_r     <= ok_next_s;
            deny_r   <= deny_next_s;
            nickel_r <= nickel_next_s;
            busy_r   <= busy_next_s;
        end
    end

    assign {a3, a2, a1, a0} = credit_r;
    assign coin_reject      = reject_r;
    assign vend_ok          = ok_r;
    assign vend_deny        = deny_r;
    assign nickel_out       = nickel_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_coin_credit_encoder.sv
// Directed self-checking bench for coin_credit_encoder (MAX 12, PRICE 7).
module tb_coin_credit_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       vend_req;
    logic       cancel;
    logic       a3, a2, a1, a0;
    logic       coin_reject, vend_ok, vend_deny, nickel_out, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // obs = {code[3:0], coin_reject, vend_ok, vend_deny, nickel_out, busy}
    logic [8:0] obs;
    logic [8:0] exp;
    assign obs = {a3, a2, a1, a0, coin_reject, vend_ok, vend_deny, nickel_out, busy};

    coin_credit_encoder #(.MAX_UNITS(12), .PRICE_UNITS(7)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .vend_req(vend_req), .cancel(cancel),
        .a3(a3), .a2(a2), .a1(a1), .a0(a0),
        .coin_reject(coin_reject), .vend_ok(vend_ok), .vend_deny(vend_deny),
        .nickel_out(nickel_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic pulse_vend();
        vend_req = 1'b1;
        step();
        vend_req = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    // Counts nickels from the current cycle until busy drops (bounded).
    task automatic drain(output int cnt, output logic ok_seen);
        cnt     = 0;
        ok_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (nickel_out) cnt++;
            if (vend_ok) ok_seen = 1'b1;
            if (!busy) break;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; vend_req = 1'b0; cancel = 1'b0;
        step(); step();
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs, exp); end
        reset = 1'b0;
        step();
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL after_release: got %b want %b", obs, exp); end
    endtask

    task automatic test_exact_price();
        coin(2'b10);
        exp = {4'd5, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL exact_quarter: got %b want %b", obs, exp); end
        coin(2'b01);
        exp = {4'd7, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL exact_dime: got %b want %b", obs, exp); end
        pulse_vend();
        exp = {4'd0, 5'b01001}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL exact_dispense: got %b want %b", obs, exp); end
        step();
        exp = {4'd0, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL exact_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_vend_change();
        coin(2'b10); coin(2'b10);
        exp = {4'd10, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL change_credit: got %b want %b", obs, exp); end
        pulse_vend();
        exp = {4'd3, 5'b01001}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL change_dispense: got %b want %b", obs, exp); end
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {4'(2 - i), 5'b00011}; n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL change_nickel%0d: got %b want %b", i, obs, exp); end
        end
        step();
        exp = {4'd0, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL change_idle: got %b want %b", obs, exp); end
    endtask

    task automatic test_overflow_slug();
        int   cnt;
        logic ok_seen;
        coin(2'b10); coin(2'b10); coin(2'b01);
        exp = {4'd12, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ovf_full: got %b want %b", obs, exp); end
        coin(2'b00);
        exp = {4'd12, 5'b10000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ovf_nickel: got %b want %b", obs, exp); end
        coin(2'b11);
        exp = {4'd12, 5'b10000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ovf_slug: got %b want %b", obs, exp); end
        pulse_cancel();
        exp = {4'd11, 5'b00011}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ovf_cancel: got %b want %b", obs, exp); end
        drain(cnt, ok_seen);
        n_checks++;
        if (cnt !== 12) begin n_fail++; $display("FAIL ovf_refund_count: got %0d want 12", cnt); end
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL ovf_end: got %b want %b", obs, exp); end
    endtask

    task automatic test_deny_cancel();
        int   cnt;
        logic ok_seen;
        coin(2'b01);
        exp = {4'd2, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL deny_dime: got %b want %b", obs, exp); end
        pulse_vend();
        exp = {4'd2, 5'b00100}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL deny_pulse: got %b want %b", obs, exp); end
        step();
        exp = {4'd2, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL deny_oneshot: got %b want %b", obs, exp); end
        pulse_cancel();
        drain(cnt, ok_seen);
        n_checks++;
        if (cnt !== 2) begin n_fail++; $display("FAIL cancel_count: got %0d want 2", cnt); end
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL cancel_end: got %b want %b", obs, exp); end
    endtask

    task automatic test_simultaneous();
        int   cnt;
        logic ok_seen;
        coin(2'b10); coin(2'b01);
        cancel = 1'b1; vend_req = 1'b1; coin_valid = 1'b1; coin_type = 2'b00;
        step();
        cancel = 1'b0; vend_req = 1'b0; coin_valid = 1'b0;
        exp = {4'd6, 5'b10011}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL simul_first: got %b want %b", obs, exp); end
        coin(2'b00);
        exp = {4'd5, 5'b10011}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL simul_coin_in_return: got %b want %b", obs, exp); end
        drain(cnt, ok_seen);
        n_checks++;
        if (cnt + 1 !== 7) begin n_fail++; $display("FAIL simul_count: got %0d want 7", cnt + 1); end
        n_checks++;
        if (ok_seen !== 1'b0) begin n_fail++; $display("FAIL simul_vend_ok: got %b want 0", ok_seen); end
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL simul_end: got %b want %b", obs, exp); end
    endtask

    task automatic test_reset_mid();
        int   cnt;
        logic ok_seen;
        coin(2'b10);
        pulse_cancel();
        step();
        exp = {4'd3, 5'b00011}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rmid_second_nickel: got %b want %b", obs, exp); end
        #2 reset = 1'b1;
        #1;
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rmid_async: got %b want %b", obs, exp); end
        step();
        reset = 1'b0;
        step();
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rmid_idle: got %b want %b", obs, exp); end
        coin(2'b00);
        exp = {4'd1, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL rmid_accepts: got %b want %b", obs, exp); end
        pulse_cancel();
        drain(cnt, ok_seen);
        n_checks++;
        if (cnt !== 1) begin n_fail++; $display("FAIL rmid_refund: got %0d want 1", cnt); end
    endtask

    task automatic test_back_to_back();
        int   cnt;
        logic ok_seen;
        pulse_vend();
        exp = {4'd0, 5'b00100}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_idle_deny: got %b want %b", obs, exp); end
        coin_valid = 1'b1; coin_type = 2'b00;
        step();
        exp = {4'd1, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_c1: got %b want %b", obs, exp); end
        coin_type = 2'b01;
        step();
        exp = {4'd3, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_c2: got %b want %b", obs, exp); end
        coin_type = 2'b00;
        step();
        exp = {4'd4, 5'b00000}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_c3: got %b want %b", obs, exp); end
        vend_req = 1'b1;
        step();
        vend_req = 1'b0; coin_valid = 1'b0;
        exp = {4'd4, 5'b10100}; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_deny_reject: got %b want %b", obs, exp); end
        pulse_cancel();
        drain(cnt, ok_seen);
        n_checks++;
        if (cnt !== 4) begin n_fail++; $display("FAIL b2b_refund: got %0d want 4", cnt); end
        exp = 9'b0000_00000; n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL b2b_end: got %b want %b", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_vend_change();
        test_overflow_slug();
        test_deny_cancel();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
